// File: rtl/rom_arbiter.sv
// Two-port round-robin (or fixed-priority) arbiter in front of a synchronous ROM.
// Define ROM_ARBITER_RR_EN for round-robin; otherwise port 0 always has priority.
module rom_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  valid0,
    input  logic                  valid1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  ready0,
    output logic                  ready1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [1:0]            dbg_state
);

    // Handshake: a port raises validN with addrN and holds both until readyN
    // pulses for one cycle; rdataN is valid in that cycle. addrN is sampled only
    // at grant, and validN still high at the next IDLE decision is a new request.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   gnt_port;
    logic   req_any;
    logic   sel;

    assign req_any   = valid0 | valid1;
    assign dbg_state = state;

`ifdef ROM_ARBITER_RR_EN
    logic last_port;

    // On contention the port that did not win last time takes the grant.
    assign sel = valid1 & (~valid0 | ~last_port);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_port <= 1'b1;
        end else if (state == IDLE && req_any) begin
            last_port <= sel;
        end
    end
`else
    assign sel = valid1 & ~valid0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = READ;
            READ:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rom_q reflects rom_addr only after the READ edge, so data is taken when leaving RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_port <= 1'b0;
            rom_addr <= '0;
            ready0   <= 1'b0;
            ready1   <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            if (state == IDLE && req_any) begin
                gnt_port <= sel;
                rom_addr <= sel ? addr1 : addr0;
            end
            if (state == RESP) begin
                if (gnt_port) begin
                    rdata1 <= rom_q;
                    ready1 <= 1'b1;
                end else begin
                    rdata0 <= rom_q;
                    ready0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: transaction-level reference model plus directed cases.
module tb_rom_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          valid0, valid1;
    logic [AW-1:0] addr0, addr1;
    logic          ready0, ready1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [1:0]    dbg_state;

    logic [DW-1:0] rom [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr];

    rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .valid0(valid0), .valid1(valid1),
        .addr0(addr0), .addr1(addr1),
        .ready0(ready0), .ready1(ready1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a read is a transaction granted at an edge, busy for three
    // edges, answered with rom[addr] two edges after grant. Expected data queue.
    logic          m_ready0, m_ready1;
    logic [DW-1:0] m_rdata0, m_rdata1;
    logic [AW-1:0] m_rom_addr;
    logic          m_last;
    int            edge_no, next_free, resp_edge;
    bit            pend;
    logic [DW:0]   exp_q[$];

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_ready0 = 0; m_ready1 = 0; m_rdata0 = '0; m_rdata1 = '0;
            m_rom_addr = '0; m_last = 1'b1; edge_no = 0; next_free = 0;
            resp_edge = 0; pend = 0; exp_q.delete();
        end else begin
            logic [DW:0] e;
            int p;
            edge_no++;
            m_ready0 = 0;
            m_ready1 = 0;
            if (pend && edge_no == resp_edge) begin
                e = exp_q.pop_front();
                pend = 0;
                if (e[DW]) begin m_ready1 = 1; m_rdata1 = e[DW-1:0]; end
                else       begin m_ready0 = 1; m_rdata0 = e[DW-1:0]; end
            end
            if (edge_no >= next_free && (valid0 || valid1)) begin
                if (valid0 && valid1) begin
`ifdef ROM_ARBITER_RR_EN
                    p = m_last ? 0 : 1;
`else
                    p = 0;
`endif
                end else begin
                    p = valid1 ? 1 : 0;
                end
                m_rom_addr = (p == 1) ? addr1 : addr0;
                exp_q.push_back({p[0], rom[m_rom_addr]});
                m_last = p[0];
                pend = 1;
                resp_edge = edge_no + 2;
                next_free = edge_no + 3;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        check("cyc_ready0", ready0, m_ready0);
        check("cyc_ready1", ready1, m_ready1);
        check("cyc_rdata0", rdata0, m_rdata0);
        check("cyc_rdata1", rdata1, m_rdata1);
        check("cyc_rom_addr", rom_addr, m_rom_addr);
        check("cyc_state_legal", dbg_state == 2'd3, 0);
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 0; valid0 = 0; valid1 = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    task automatic await_ready(input int max, output int lat, output int port);
        lat = -1;
        port = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (ready0 || ready1) begin
                lat = i;
                port = ready1 ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready0"}, ready0, 0);
        check({tag, "_ready1"}, ready1, 0);
        check({tag, "_rdata0"}, rdata0, 0);
        check({tag, "_rdata1"}, rdata1, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
    endtask

    initial begin
        int lat, port, k, n0, n1, fp, fc, sp, sc;
        int seq_p[4];
        logic [DW-1:0] seq_d[4];
        logic [DW-1:0] sd;

        for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
        rom[10'h005] = 32'hDEADBEEF;
        rom[10'h001] = 32'h11111111;
        rom[10'h002] = 32'h22222222;
        rom[10'h3FF] = 32'hCAFEF00D;
        rom[10'h010] = 32'h01001000;
        rom[10'h020] = 32'h02002000;
        valid0 = 0; valid1 = 0; addr0 = '0; addr1 = '0;

        #2 resetn = 0;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        resetn = 1;

        // Single read
        @(negedge clk);
        valid0 = 1; addr0 = 10'h005;
        await_ready(8, lat, port);
        valid0 = 0;
        check("single_latency", lat, 3);
        check("single_port", port, 0);
        check("single_rdata0", rdata0, 32'hDEADBEEF);
        repeat (2) @(negedge clk);

        // Continuous contention from reset
        do_reset();
        @(negedge clk);
        valid0 = 1; valid1 = 1; addr0 = 10'h001; addr1 = 10'h002;
        k = 0; n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin seq_p[i] = -1; seq_d[i] = '0; end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ready0) begin n0++; if (k < 4) begin seq_p[k] = 0; seq_d[k] = rdata0; k++; end end
            if (ready1) begin n1++; if (k < 4) begin seq_p[k] = 1; seq_d[k] = rdata1; k++; end end
            if (i == 12) begin valid0 = 0; valid1 = 0; end
        end
`ifdef ROM_ARBITER_RR_EN
        check("rr_count", k, 4);
        check("rr_p0", seq_p[0], 0);
        check("rr_p1", seq_p[1], 1);
        check("rr_p2", seq_p[2], 0);
        check("rr_p3", seq_p[3], 1);
        check("rr_d0", seq_d[0], 32'h11111111);
        check("rr_d1", seq_d[1], 32'h22222222);
        check("rr_d2", seq_d[2], 32'h11111111);
        check("rr_d3", seq_d[3], 32'h22222222);
`else
        check("fixed_n0", n0, 4);
        check("fixed_n1", n1, 0);
        check("fixed_d0", seq_d[0], 32'h11111111);
        check("fixed_d3", seq_d[3], 32'h11111111);
`endif
        repeat (2) @(negedge clk);

        // Late arrival on port 1 during port-0 READ
        valid0 = 1; addr0 = 10'h005;
        @(negedge clk);
        valid1 = 1; addr1 = 10'h3FF;
        fp = -1; fc = -1; sp = -1; sc = -1; sd = '0;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (ready0 || ready1) begin
                port = ready1 ? 1 : 0;
                if (fp < 0) begin fp = port; fc = i; end
                else if (sp < 0) begin sp = port; sc = i; sd = port ? rdata1 : rdata0; end
                if (port == 1) valid1 = 0; else valid0 = 0;
            end
        end
        check("late_first_port", fp, 0);
        check("late_first_cycle", fc, 3);
        check("late_second_port", sp, 1);
        check("late_second_cycle", sc, 6);
        check("late_rdata1", sd, 32'hCAFEF00D);

        // Address change after grant
        @(negedge clk);
        valid0 = 1; addr0 = 10'h010;
        @(negedge clk);
        addr0 = 10'h020;
        await_ready(8, lat, port);
        valid0 = 0;
        check("addrchg_latency", lat, 2);
        check("addrchg_rdata0", rdata0, 32'h01001000);
        repeat (2) @(negedge clk);

        // Reset in the READ cycle aborts the read
        valid0 = 1; addr0 = 10'h010;
        @(negedge clk);
        resetn = 0; valid0 = 0;
        #1 check_zero_outputs("midrst");
        n0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready0 || ready1) n0++;
        end
        check("midrst_no_ready", n0, 0);
        resetn = 1;
        @(negedge clk);
        valid0 = 1; valid1 = 1; addr0 = 10'h001; addr1 = 10'h002;
        await_ready(8, lat, port);
        valid0 = 0; valid1 = 0;
        check("postrst_latency", lat, 3);
        check("postrst_port", port, 0);
        check("postrst_rdata0", rdata0, 32'h11111111);
        repeat (3) @(negedge clk);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                resetn = 0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                resetn = 1;
            end
            if ($urandom_range(0, 3) == 0) valid0 = ~valid0;
            if ($urandom_range(0, 3) == 0) valid1 = ~valid1;
            if ($urandom_range(0, 1) == 0) addr0 = AW'($urandom_range(0, (1 << AW) - 1));
            if ($urandom_range(0, 1) == 0) addr1 = AW'($urandom_range(0, 15));
        end
        @(negedge clk);
        valid0 = 0; valid1 = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
